// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers EX results, runs loads/stores over a req/ready
// data-memory handshake with a timeout, stalls upstream while busy and drives MEM/WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    input  logic [31:0] aluResult,
    input  logic [31:0] aluReadData2,
    input  logic [4:0]  rdOrRt,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic        memToReg,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_regWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        wb_err_code
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {StIdle, StAccess} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     lat_alu_q, lat_alu_d;
    logic [4:0]      lat_rd_q, lat_rd_d;
    logic            lat_regwrite_q, lat_regwrite_d;
    logic            lat_memtoreg_q, lat_memtoreg_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_regwrite_q, wb_regwrite_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            wb_err_q, wb_err_d;
    logic            wb_err_code_q, wb_err_code_d;

    logic is_mem, misaligned, timeout_hit;

    assign is_mem      = memRead | memWrite;
    assign misaligned  = aluResult[1:0] != 2'b00;
    assign timeout_hit = cnt_q == CntW'(TIMEOUT - 1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            lat_alu_q      <= '0;
            lat_rd_q       <= '0;
            lat_regwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_err_q       <= 1'b0;
            wb_err_code_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lat_alu_q      <= lat_alu_d;
            lat_rd_q       <= lat_rd_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_err_q       <= wb_err_d;
            wb_err_code_q  <= wb_err_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_valid && is_mem && !misaligned) state_d = StAccess;
            StAccess: if (dmem_ready || timeout_hit) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        stall          = 1'b0;
        cnt_d          = cnt_q;
        lat_alu_d      = lat_alu_q;
        lat_rd_d       = lat_rd_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        // Bubble unless a retire below overrides.
        wb_valid_d     = 1'b0;
        wb_regwrite_d  = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_err_d       = 1'b0;
        wb_err_code_d  = wb_err_code_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d    = 1'b1;
                        wb_regwrite_d = regWrite;
                        wb_rd_d       = rdOrRt;
                        wb_data_d     = aluResult;
                    end else if (misaligned) begin
                        wb_valid_d    = 1'b1;
                        wb_rd_d       = rdOrRt;
                        wb_data_d     = aluResult;
                        wb_err_d      = 1'b1;
                        wb_err_code_d = 1'b0;
                    end else begin
                        stall          = 1'b1;
                        cnt_d          = '0;
                        lat_alu_d      = aluResult;
                        lat_rd_d       = rdOrRt;
                        lat_regwrite_d = regWrite;
                        lat_memtoreg_d = memToReg;
                        req_d          = 1'b1;
                        we_d           = memWrite & ~memRead;
                        addr_d         = {aluResult[31:2], 2'b00};
                        wdata_d        = aluReadData2;
                    end
                end
            end
            StAccess: begin
                // Ready wins over timeout when both land on the same edge.
                if (dmem_ready) begin
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = lat_regwrite_q;
                    wb_rd_d       = lat_rd_q;
                    wb_data_d     = lat_memtoreg_q ? dmem_rdata : lat_alu_q;
                end else if (timeout_hit) begin
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = lat_rd_q;
                    wb_err_d      = 1'b1;
                    wb_err_code_d = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_regWrite = wb_regwrite_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_err      = wb_err_q;
    assign wb_err_code = wb_err_code_q;

endmodule
